frame_serializer: RTL and testbench

FRAME_SERIALIZER -- requirements
Module: frame_serializer

---
 rtl/can_pkg.sv | 17 +
 rtl/frame_serializer_if.sv | 37 +++
 rtl/bit_stuffer.sv | 37 +++
 rtl/frame_serializer.sv | 157 +++++++++++++++
 tb/tb_frame_serializer.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/can_pkg.sv
// Shared CAN definitions for the frame serializer and frame storage blocks.
package can_pkg;

  localparam int unsigned FRAME_W_DEF   = 590;
  localparam int unsigned STUFF_RUN_DEF = 5;
  localparam int unsigned LEN_W         = 10;

  typedef logic [LEN_W-1:0] frame_len_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TP,
    DATA,
    STUFF
  } ser_state_t;

endpackage

// File: rtl/frame_serializer_if.sv
// Frame request/status handshake between a frame source and the serializer.
interface frame_serializer_if import can_pkg::*; #(
  parameter int unsigned FRAME_W = FRAME_W_DEF
) ();

  logic               start;
  logic [FRAME_W-1:0] frame;
  frame_len_t         frame_len;
  frame_len_t         stuff_len;
  frame_len_t         arb_len;
  logic               busy;
  logic               done;
  logic               arb_lost;

  modport master (
    output start,
    output frame,
    output frame_len,
    output stuff_len,
    output arb_len,
    input  busy,
    input  done,
    input  arb_lost
  );

  modport slave (
    input  start,
    input  frame,
    input  frame_len,
    input  stuff_len,
    input  arb_len,
    output busy,
    output done,
    output arb_lost
  );

endinterface

// File: rtl/bit_stuffer.sv
// Tracks the run of equal driven bus bits and flags when a stuff bit is due.
module bit_stuffer import can_pkg::*; #(
  parameter int unsigned STUFF_RUN = STUFF_RUN_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic shift,
  input  logic bit_in,
  input  logic last_bit,
  input  logic stuffable,
  output logic stuff_due
);

  localparam int unsigned     CNT_W   = $clog2(STUFF_RUN + 1);
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(STUFF_RUN);

  logic [CNT_W-1:0] run_cnt;

  // A zero count marks "nothing driven yet", so the first bit always starts a run of 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_cnt <= '0;
    end else if (clr) begin
      run_cnt <= '0;
    end else if (shift) begin
      if (run_cnt == '0 || bit_in != last_bit) begin
        run_cnt <= CNT_W'(1);
      end else if (run_cnt != RUN_MAX) begin
        run_cnt <= run_cnt + CNT_W'(1);
      end
    end
  end

  assign stuff_due = stuffable && (run_cnt == RUN_MAX);

endmodule

// File: rtl/frame_serializer.sv
// Serialises a latched frame onto the CAN bus with bit stuffing and
// arbitration-loss detection, paced by external tp/sp strobes.
module frame_serializer import can_pkg::*; #(
  parameter int unsigned FRAME_W   = FRAME_W_DEF,
  parameter int unsigned STUFF_RUN = STUFF_RUN_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tp,
  input  logic              sp,
  input  logic              CAN_RX,
  output logic              CAN_TX,
  output logic              isStuff,
  frame_serializer_if.slave req
);

  ser_state_t         state;
  logic [FRAME_W-1:0] frame_q;
  frame_len_t         frame_len_q;
  frame_len_t         stuff_len_q;
  frame_len_t         arb_len_q;
  frame_len_t         sent;
  frame_len_t         align_sh;
  logic               busy_q;
  logic               done_q;
  logic               arb_lost_q;

  logic drive_en;
  logic drive_bit;
  logic drive_stuff;
  logic frame_end;
  logic last_sent;
  logic arb_hit;
  logic stuffable;
  logic stuff_due;

  // Frame is left-aligned on load so the next bit to send is always the MSB.
  assign align_sh  = frame_len_t'(FRAME_W) - req.frame_len;
  assign last_sent = (sent == frame_len_q);
  assign stuffable = (state == DATA) && (sent <= stuff_len_q);
  assign arb_hit   = sp && !tp && (state == DATA) && (sent <= arb_len_q)
                     && CAN_TX && !CAN_RX;

  always_comb begin
    drive_en    = 1'b0;
    drive_bit   = frame_q[FRAME_W-1];
    drive_stuff = 1'b0;
    frame_end   = 1'b0;
    if (tp) begin
      unique case (state)
        WAIT_TP: drive_en = 1'b1;
        DATA: begin
          if (stuff_due) begin
            drive_en    = 1'b1;
            drive_bit   = ~CAN_TX;
            drive_stuff = 1'b1;
          end else if (last_sent) begin
            frame_end = 1'b1;
          end else begin
            drive_en = 1'b1;
          end
        end
        STUFF: begin
          if (last_sent) frame_end = 1'b1;
          else           drive_en  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  bit_stuffer #(
    .STUFF_RUN(STUFF_RUN)
  ) u_stuffer (
    .clk      (clk),
    .reset    (reset),
    .clr      (state == IDLE),
    .shift    (drive_en),
    .bit_in   (drive_bit),
    .last_bit (CAN_TX),
    .stuffable(stuffable),
    .stuff_due(stuff_due)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      CAN_TX      <= 1'b1;
      isStuff     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      arb_lost_q  <= 1'b0;
      sent        <= '0;
      frame_q     <= '0;
      frame_len_q <= '0;
      stuff_len_q <= '0;
      arb_len_q   <= '0;
    end else begin
      done_q     <= 1'b0;
      arb_lost_q <= 1'b0;
      unique case (state)
        IDLE: begin
          CAN_TX  <= 1'b1;
          isStuff <= 1'b0;
          if (req.start) begin
            frame_q     <= req.frame << align_sh;
            frame_len_q <= req.frame_len;
            stuff_len_q <= req.stuff_len;
            arb_len_q   <= req.arb_len;
            sent        <= '0;
            busy_q      <= 1'b1;
            state       <= WAIT_TP;
          end
        end
        default: begin
          if (frame_end) begin
            CAN_TX  <= 1'b1;
            isStuff <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            sent    <= '0;
            state   <= IDLE;
          end else if (drive_en) begin
            CAN_TX  <= drive_bit;
            isStuff <= drive_stuff;
            if (drive_stuff) begin
              state <= STUFF;
            end else begin
              frame_q <= frame_q << 1;
              sent    <= sent + frame_len_t'(1);
              state   <= DATA;
            end
          end else if (arb_hit) begin
            CAN_TX     <= 1'b1;
            isStuff    <= 1'b0;
            busy_q     <= 1'b0;
            arb_lost_q <= 1'b1;
            sent       <= '0;
            state      <= IDLE;
          end
        end
      endcase
    end
  end

  assign req.busy     = busy_q;
  assign req.done     = done_q;
  assign req.arb_lost = arb_lost_q;

  a_pulses_exclusive: assert property (@(posedge clk) disable iff (!reset)
    !(done_q && arb_lost_q));
  a_stuff_while_busy: assert property (@(posedge clk) disable iff (!reset)
    isStuff |-> busy_q);
  a_idle_recessive: assert property (@(posedge clk) disable iff (!reset)
    (state == IDLE) |-> (CAN_TX && !isStuff));

endmodule

// File: tb/tb_frame_serializer.sv
// Directed bench for frame_serializer: stuffing, arbitration, reset and start handling.
module tb_frame_serializer;

  logic        clk;
  logic        reset;
  logic        tp;
  logic        sp;
  logic        rx_dom;
  logic        can_rx;
  logic        can_tx;
  logic        is_stuff;
  int unsigned passed;
  int unsigned total;

  frame_serializer_if ifc ();

  // Wired-AND bus: another node can pull the line dominant via rx_dom.
  assign can_rx = can_tx & ~rx_dom;

  frame_serializer dut (
    .clk    (clk),
    .reset  (reset),
    .tp     (tp),
    .sp     (sp),
    .CAN_RX (can_rx),
    .CAN_TX (can_tx),
    .isStuff(is_stuff),
    .req    (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", passed, total);
    $fatal(1);
  end

  task automatic tp_pulse();
    tp = 1'b1;
    @(negedge clk);
    tp = 1'b0;
  endtask

  task automatic sp_pulse(input logic dom);
    repeat (2) @(negedge clk);
    rx_dom = dom;
    sp     = 1'b1;
    @(negedge clk);
    sp     = 1'b0;
    rx_dom = 1'b0;
  endtask

  task automatic start_frame(input logic [7:0] f, input logic [9:0] len,
                             input logic [9:0] sl, input logic [9:0] al);
    ifc.frame      = '0;
    ifc.frame[7:0] = f;
    ifc.frame_len  = len;
    ifc.stuff_len  = sl;
    ifc.arb_len    = al;
    ifc.start      = 1'b1;
    @(negedge clk);
    ifc.start      = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; tp = 1'b0; sp = 1'b0; rx_dom = 1'b0;
    ifc.start = 1'b0; ifc.frame = '0;
    ifc.frame_len = '0; ifc.stuff_len = '0; ifc.arb_len = '0;
    repeat (3) @(negedge clk);
    total++; if (can_tx !== 1'b1) $display("FAIL rst_can_tx: got %b want 1", can_tx); else passed++;
    total++; if (is_stuff !== 1'b0) $display("FAIL rst_is_stuff: got %b want 0", is_stuff); else passed++;
    total++; if (ifc.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", ifc.busy); else passed++;
    total++; if (ifc.done !== 1'b0) $display("FAIL rst_done: got %b want 0", ifc.done); else passed++;
    total++; if (ifc.arb_lost !== 1'b0) $display("FAIL rst_arb_lost: got %b want 0", ifc.arb_lost); else passed++;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (can_tx !== 1'b1) $display("FAIL rst_release_can_tx: got %b want 1", can_tx); else passed++;
  endtask

  task automatic test_stuff_zeros();
    logic [8:0] exp_tx;
    logic [8:0] exp_st;
    exp_tx = 9'b000001111;
    exp_st = 9'b000001000;
    start_frame(8'b00000111, 10'd8, 10'd8, 10'd8);
    total++; if (ifc.busy !== 1'b1) $display("FAIL z_busy_start: got %b want 1", ifc.busy); else passed++;
    for (int unsigned i = 0; i < 9; i++) begin
      tp_pulse();
      total++; if (can_tx !== exp_tx[8-i]) $display("FAIL z_tx[%0d]: got %b want %b", i, can_tx, exp_tx[8-i]); else passed++;
      total++; if (is_stuff !== exp_st[8-i]) $display("FAIL z_stuff[%0d]: got %b want %b", i, is_stuff, exp_st[8-i]); else passed++;
      // Bus forced dominant under the recessive stuff bit: must not count as arbitration loss.
      sp_pulse(exp_st[8-i]);
    end
    total++; if (ifc.busy !== 1'b1) $display("FAIL z_busy_after_stuff_sp: got %b want 1", ifc.busy); else passed++;
    tp_pulse();
    total++; if (ifc.done !== 1'b1) $display("FAIL z_done: got %b want 1", ifc.done); else passed++;
    total++; if (ifc.busy !== 1'b0) $display("FAIL z_busy_end: got %b want 0", ifc.busy); else passed++;
    total++; if (can_tx !== 1'b1) $display("FAIL z_tx_end: got %b want 1", can_tx); else passed++;
    @(negedge clk);
    total++; if (ifc.done !== 1'b0) $display("FAIL z_done_pulse: got %b want 0", ifc.done); else passed++;
  endtask

  task automatic test_stuff_ones();
    logic [8:0] exp_tx;
    logic [8:0] exp_st;
    exp_tx = 9'b111110000;
    exp_st = 9'b000001000;
    start_frame(8'b11111000, 10'd8, 10'd8, 10'd0);
    for (int unsigned i = 0; i < 9; i++) begin
      tp_pulse();
      total++; if (can_tx !== exp_tx[8-i]) $display("FAIL o_tx[%0d]: got %b want %b", i, can_tx, exp_tx[8-i]); else passed++;
      total++; if (is_stuff !== exp_st[8-i]) $display("FAIL o_stuff[%0d]: got %b want %b", i, is_stuff, exp_st[8-i]); else passed++;
      sp_pulse(1'b0);
    end
    tp_pulse();
    total++; if (ifc.done !== 1'b1) $display("FAIL o_done: got %b want 1", ifc.done); else passed++;
    total++; if (can_tx !== 1'b1) $display("FAIL o_tx_end: got %b want 1", can_tx); else passed++;
    @(negedge clk);
  endtask

  task automatic test_no_stuff();
    logic [7:0] exp_tx;
    exp_tx = 8'b00000111;
    start_frame(8'b00000111, 10'd8, 10'd4, 10'd0);
    for (int unsigned i = 0; i < 8; i++) begin
      tp_pulse();
      total++; if (can_tx !== exp_tx[7-i]) $display("FAIL ns_tx[%0d]: got %b want %b", i, can_tx, exp_tx[7-i]); else passed++;
      total++; if (is_stuff !== 1'b0) $display("FAIL ns_stuff[%0d]: got %b want 0", i, is_stuff); else passed++;
      sp_pulse(1'b0);
    end
    tp_pulse();
    total++; if (ifc.done !== 1'b1) $display("FAIL ns_done: got %b want 1", ifc.done); else passed++;
    @(negedge clk);
    // stuff_len=0: eight equal bits go out unstuffed.
    start_frame(8'b00000000, 10'd8, 10'd0, 10'd0);
    for (int unsigned i = 0; i < 8; i++) begin
      tp_pulse();
      total++; if (can_tx !== 1'b0) $display("FAIL sl0_tx[%0d]: got %b want 0", i, can_tx); else passed++;
      total++; if (is_stuff !== 1'b0) $display("FAIL sl0_stuff[%0d]: got %b want 0", i, is_stuff); else passed++;
      sp_pulse(1'b0);
    end
    tp_pulse();
    total++; if (ifc.done !== 1'b1) $display("FAIL sl0_done: got %b want 1", ifc.done); else passed++;
    @(negedge clk);
  endtask

  task automatic test_trailing_stuff();
    logic [5:0] exp_tx;
    logic [5:0] exp_st;
    exp_tx = 6'b000001;
    exp_st = 6'b000001;
    start_frame(8'b00000000, 10'd5, 10'd5, 10'd0);
    for (int unsigned i = 0; i < 6; i++) begin
      tp_pulse();
      total++; if (can_tx !== exp_tx[5-i]) $display("FAIL ts_tx[%0d]: got %b want %b", i, can_tx, exp_tx[5-i]); else passed++;
      total++; if (is_stuff !== exp_st[5-i]) $display("FAIL ts_stuff[%0d]: got %b want %b", i, is_stuff, exp_st[5-i]); else passed++;
      sp_pulse(1'b0);
    end
    tp_pulse();
    total++; if (ifc.done !== 1'b1) $display("FAIL ts_done: got %b want 1", ifc.done); else passed++;
    total++; if (is_stuff !== 1'b0) $display("FAIL ts_stuff_end: got %b want 0", is_stuff); else passed++;
    @(negedge clk);
    // Single-bit frame.
    start_frame(8'b00000000, 10'd1, 10'd1, 10'd0);
    tp_pulse();
    total++; if (can_tx !== 1'b0) $display("FAIL len1_tx: got %b want 0", can_tx); else passed++;
    sp_pulse(1'b0);
    tp_pulse();
    total++; if (ifc.done !== 1'b1) $display("FAIL len1_done: got %b want 1", ifc.done); else passed++;
    total++; if (can_tx !== 1'b1) $display("FAIL len1_tx_end: got %b want 1", can_tx); else passed++;
    @(negedge clk);
  endtask

  task automatic test_arbitration();
    logic [7:0] exp_tx;
    // Recessive bit at index 3 lies outside arb_len=3: a dominant bus there is not a loss.
    exp_tx = 8'b00010000;
    start_frame(8'b00010000, 10'd8, 10'd8, 10'd3);
    for (int unsigned i = 0; i < 8; i++) begin
      tp_pulse();
      total++; if (can_tx !== exp_tx[7-i]) $display("FAIL ab_tx[%0d]: got %b want %b", i, can_tx, exp_tx[7-i]); else passed++;
      sp_pulse(i == 3);
      if (i == 3) begin
        total++; if (ifc.arb_lost !== 1'b0) $display("FAIL ab_no_loss: got %b want 0", ifc.arb_lost); else passed++;
        total++; if (ifc.busy !== 1'b1) $display("FAIL ab_busy: got %b want 1", ifc.busy); else passed++;
      end
    end
    tp_pulse();
    total++; if (ifc.done !== 1'b1) $display("FAIL ab_done: got %b want 1", ifc.done); else passed++;
    @(negedge clk);
    start_frame(8'b01100000, 10'd8, 10'd8, 10'd3);
    tp_pulse();
    total++; if (can_tx !== 1'b0) $display("FAIL al_tx0: got %b want 0", can_tx); else passed++;
    sp_pulse(1'b0);
    tp_pulse();
    total++; if (can_tx !== 1'b1) $display("FAIL al_tx1: got %b want 1", can_tx); else passed++;
    sp_pulse(1'b1);
    total++; if (ifc.arb_lost !== 1'b1) $display("FAIL al_pulse: got %b want 1", ifc.arb_lost); else passed++;
    total++; if (can_tx !== 1'b1) $display("FAIL al_tx: got %b want 1", can_tx); else passed++;
    total++; if (ifc.busy !== 1'b0) $display("FAIL al_busy: got %b want 0", ifc.busy); else passed++;
    @(negedge clk);
    total++; if (ifc.arb_lost !== 1'b0) $display("FAIL al_pulse_len: got %b want 0", ifc.arb_lost); else passed++;
    tp_pulse();
    total++; if (can_tx !== 1'b1) $display("FAIL al_idle_tx: got %b want 1", can_tx); else passed++;
    total++; if (ifc.done !== 1'b0) $display("FAIL al_no_done: got %b want 0", ifc.done); else passed++;
  endtask

  task automatic test_reset_midframe();
    logic [7:0] exp_tx;
    start_frame(8'b10100101, 10'd8, 10'd8, 10'd8);
    for (int unsigned i = 0; i < 5; i++) begin
      tp_pulse();
      if (i < 4) sp_pulse(1'b0);
    end
    total++; if (can_tx !== 1'b0) $display("FAIL mr_tx_bit4: got %b want 0", can_tx); else passed++;
    #2 reset = 1'b0;
    #1;
    total++; if (can_tx !== 1'b1) $display("FAIL mr_async_tx: got %b want 1", can_tx); else passed++;
    total++; if (ifc.busy !== 1'b0) $display("FAIL mr_async_busy: got %b want 0", ifc.busy); else passed++;
    total++; if (is_stuff !== 1'b0) $display("FAIL mr_async_stuff: got %b want 0", is_stuff); else passed++;
    @(negedge clk);
    tp_pulse();
    total++; if (can_tx !== 1'b1) $display("FAIL mr_tp_in_reset: got %b want 1", can_tx); else passed++;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    exp_tx = 8'b01110010;
    start_frame(8'b01110010, 10'd8, 10'd8, 10'd8);
    total++; if (ifc.busy !== 1'b1) $display("FAIL mr_restart_busy: got %b want 1", ifc.busy); else passed++;
    for (int unsigned i = 0; i < 8; i++) begin
      tp_pulse();
      total++; if (can_tx !== exp_tx[7-i]) $display("FAIL mr_tx[%0d]: got %b want %b", i, can_tx, exp_tx[7-i]); else passed++;
      sp_pulse(1'b0);
    end
    tp_pulse();
    total++; if (ifc.done !== 1'b1) $display("FAIL mr_done: got %b want 1", ifc.done); else passed++;
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    logic [7:0] exp_tx;
    exp_tx = 8'b11001010;
    start_frame(8'b11001010, 10'd8, 10'd8, 10'd0);
    for (int unsigned i = 0; i < 8; i++) begin
      tp_pulse();
      total++; if (can_tx !== exp_tx[7-i]) $display("FAIL si_tx[%0d]: got %b want %b", i, can_tx, exp_tx[7-i]); else passed++;
      if (i == 2) begin
        ifc.frame[7:0] = 8'b00110101;
        ifc.frame_len  = 10'd4;
        ifc.stuff_len  = 10'd4;
        ifc.start      = 1'b1;
        @(negedge clk);
        ifc.start      = 1'b0;
        total++; if (ifc.busy !== 1'b1) $display("FAIL si_busy: got %b want 1", ifc.busy); else passed++;
      end
      sp_pulse(1'b0);
    end
    total++; if (ifc.done !== 1'b0) $display("FAIL si_early_done: got %b want 0", ifc.done); else passed++;
    tp_pulse();
    total++; if (ifc.done !== 1'b1) $display("FAIL si_done: got %b want 1", ifc.done); else passed++;
    total++; if (ifc.busy !== 1'b0) $display("FAIL si_busy_end: got %b want 0", ifc.busy); else passed++;
    @(negedge clk);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_stuff_zeros();
    test_stuff_ones();
    test_no_stuff();
    test_trailing_stuff();
    test_arbitration();
    test_reset_midframe();
    test_start_ignored();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
